bram_arbiter: RTL

Two-port arbiter and access sequencer for the user-area 32-bit BRAM. It shares the single BRAM port between the Wishbone slave interface and a secondary master port (M1), which is used by LA-driven or accelerator logic. For each granted access it holds the BRAM enable for a programmable number of wait cycles, captures the read data and returns a one-cycle acknowledge to the winning requester. It sits between the Wishbone slave ports of the user project and the `bram` instance.

---
 rtl/bram_arbiter.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/bram_arbiter.sv
// bram_arbiter: shares one 32-bit BRAM port between the Wishbone slave (WB) and
// a secondary master (M1). Round-robin on ties. Each grant holds the BRAM
// enable for DELAYS-1 cycles, captures the read data, then pulses the winner's
// ack for one cycle.
// Ports:
//   wb_clk_i, wb_rst_n            clock, async active-low reset
//   wbs_*                         Wishbone slave request / response
//   m1_*                          secondary master request / response
//   bram_en_o/we_o/a_o/di_o/do_i  BRAM port
//   busy_o                        FSM not idle
//   owner_o                       current or last grant (0 = WB, 1 = M1)
module bram_arbiter #(
  parameter int unsigned DELAYS    = 10,
  parameter logic [7:0]  ADDR_BASE = 8'h38
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  input  logic        m1_req_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_sel_i,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  output logic        m1_ack_o,
  output logic [31:0] m1_dat_o,
  output logic        bram_en_o,
  output logic [3:0]  bram_we_o,
  output logic [31:0] bram_a_o,
  output logic [31:0] bram_di_o,
  input  logic [31:0] bram_do_i,
  output logic        busy_o,
  output logic        owner_o
);

  localparam int unsigned CNT_W = 5;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_ACK    = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_n;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_n;
  logic               r_last_grant;
  logic               w_last_grant_n;
  logic               w_owner_n;
  logic               w_grant;
  logic               w_sample;
  logic               r_recover;
  logic [31:0]        r_rdata;

  logic               w_wb_req;
  logic               w_m1_req;
  logic               w_owner_req;
  logic [3:0]         w_sel_we;
  logic [31:0]        w_adr;
  logic [31:0]        w_di;

  // Request terms; a WB request outside the BRAM window is invisible here
  assign w_wb_req    = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:24] == ADDR_BASE);
  assign w_m1_req    = m1_req_i;
  assign w_owner_req = owner_o ? w_m1_req : w_wb_req;

  // Controls of the requester selected by this cycle's arbitration
  assign w_sel_we = w_owner_n ? (m1_sel_i & {4{m1_we_i}}) : (wbs_sel_i & {4{wbs_we_i}});
  assign w_adr    = w_owner_n ? m1_adr_i : wbs_adr_i;
  assign w_di     = w_owner_n ? m1_dat_i : wbs_dat_i;

  assign wbs_dat_o = r_rdata;
  assign m1_dat_o  = r_rdata;

  // State register
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_last_grant <= 1'b1;
    end else begin
      r_state      <= w_state_n;
      r_cnt        <= w_cnt_n;
      r_last_grant <= w_last_grant_n;
    end
  end

  // Arbitration and sequencing
  always_comb begin
    w_state_n      = r_state;
    w_cnt_n        = r_cnt;
    w_last_grant_n = r_last_grant;
    w_owner_n      = owner_o;
    w_grant        = 1'b0;
    w_sample       = 1'b0;
    case (r_state)
      S_IDLE: begin
        // The IDLE cycle right after an ACK only lets stale requests settle
        if (!r_recover && (w_wb_req || w_m1_req)) begin
          w_grant        = 1'b1;
          w_owner_n      = (w_wb_req && w_m1_req) ? ~r_last_grant : w_m1_req;
          w_last_grant_n = w_owner_n;
          w_cnt_n        = '0;
          w_state_n      = S_ACCESS;
        end
      end
      S_ACCESS: begin
        w_cnt_n = r_cnt + CNT_W'(1);
        // A withdrawn request aborts without ack, even on the last cycle
        if (!w_owner_req) begin
          w_state_n = S_IDLE;
        end else if (r_cnt == CNT_W'(DELAYS - 2)) begin
          w_sample  = 1'b1;
          w_state_n = S_ACK;
        end
      end
      S_ACK: begin
        w_state_n = S_IDLE;
      end
      default: begin
        w_state_n = S_IDLE;
      end
    endcase
  end

  // Registered outputs, derived from the next state so they align with it
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      owner_o   <= 1'b0;
      bram_en_o <= 1'b0;
      bram_we_o <= '0;
      bram_a_o  <= '0;
      bram_di_o <= '0;
      r_rdata   <= '0;
      wbs_ack_o <= 1'b0;
      m1_ack_o  <= 1'b0;
      busy_o    <= 1'b0;
      r_recover <= 1'b0;
    end else begin
      owner_o   <= w_owner_n;
      bram_en_o <= (w_state_n == S_ACCESS);
      // Write strobes only in the first ACCESS cycle
      bram_we_o <= w_grant ? w_sel_we : 4'h0;
      if (w_grant) begin
        bram_a_o  <= w_adr;
        bram_di_o <= w_di;
      end
      if (w_sample) begin
        r_rdata <= bram_do_i;
      end
      wbs_ack_o <= (w_state_n == S_ACK) && !w_owner_n;
      m1_ack_o  <= (w_state_n == S_ACK) &&  w_owner_n;
      busy_o    <= (w_state_n != S_IDLE);
      r_recover <= (r_state == S_ACK);
    end
  end

endmodule
